// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared func encodings, FSM state codes and width helper for alu_mc.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [4:0] F_ADD    = 5'h00;
   localparam logic [4:0] F_SLT    = 5'h01;
   localparam logic [4:0] F_SLTU   = 5'h02;
   localparam logic [4:0] F_AND    = 5'h03;
   localparam logic [4:0] F_OR     = 5'h04;
   localparam logic [4:0] F_XOR    = 5'h05;
   localparam logic [4:0] F_SLL    = 5'h06;
   localparam logic [4:0] F_SRL    = 5'h07;
   localparam logic [4:0] F_SUB    = 5'h08;
   localparam logic [4:0] F_SRA    = 5'h09;
   localparam logic [4:0] F_MUL    = 5'h10;
   localparam logic [4:0] F_MULH   = 5'h11;
   localparam logic [4:0] F_MULHSU = 5'h12;
   localparam logic [4:0] F_MULHU  = 5'h13;
   localparam logic [4:0] F_DIV    = 5'h14;
   localparam logic [4:0] F_DIVU   = 5'h15;
   localparam logic [4:0] F_REM    = 5'h16;
   localparam logic [4:0] F_REMU   = 5'h17;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic int shamt_w(input int xlen);
      return $clog2(xlen);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module : alu_muldiv_iter
// Brief  : Bit-serial shift-add multiply / restoring divide on magnitudes,
//          with sign fix-up and single-cycle divide special-case bypass.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_done,
   output logic [XLEN-1:0] o_res,
   output logic            o_bypass,
   output logic [XLEN-1:0] o_bypass_res
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic            w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic [XLEN-1:0] w_a_mag, w_b_mag;

   logic            r_run, r_div, r_neg_q, r_neg_r;
   logic [1:0]      r_sel;
   logic [CW-1:0]   r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0] r_opd;

   logic [XLEN:0]     w_sum, w_shl, w_diff;
   logic              w_ge;
   logic [2*XLEN-1:0] w_nx, w_prod;
   logic [XLEN-1:0]   w_q, w_r;

   // Divide: both signed unless func[0]; multiply: MULHU unsigned, MULHSU signed a only
   assign w_is_div = i_op[2];
   assign w_a_sgn  = w_is_div ? !i_op[0] : (i_op[1:0] != 2'b11);
   assign w_b_sgn  = w_is_div ? !i_op[0] : !i_op[1];
   assign w_a_neg  = w_a_sgn & i_a[XLEN-1];
   assign w_b_neg  = w_b_sgn & i_b[XLEN-1];
   assign w_a_mag  = w_a_neg ? -i_a : i_a;
   assign w_b_mag  = w_b_neg ? -i_b : i_b;

   assign o_bypass = w_is_div && ((i_b == '0) ||
                     (!i_op[0] && (i_a == C_MIN) && (i_b == '1)));
   assign o_bypass_res = (i_b == '0) ? (i_op[1] ? i_a : '1)
                                     : (i_op[1] ? '0 : C_MIN);

   // r_acc is {hi, lo}: product/multiplier for multiply, remainder/quotient for divide
   assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opd : '0)};
   assign w_shl  = r_acc[2*XLEN-1:XLEN-1];
   assign w_diff = w_shl - {1'b0, r_opd};
   assign w_ge   = !w_diff[XLEN];
   assign w_nx   = r_div ? {(w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0]),
                            r_acc[XLEN-2:0], w_ge}
                         : {w_sum, r_acc[XLEN-1:1]};

   assign w_prod = r_neg_q ? -w_nx : w_nx;
   assign w_q    = r_neg_q ? -w_nx[XLEN-1:0] : w_nx[XLEN-1:0];
   assign w_r    = r_neg_r ? -w_nx[2*XLEN-1:XLEN] : w_nx[2*XLEN-1:XLEN];

   assign o_done = r_run && (r_cnt == CW'(XLEN-1));
   assign o_res  = r_div ? (r_sel[1] ? w_r : w_q)
                         : ((r_sel == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run   <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opd   <= '0;
         r_div   <= 1'b0;
         r_sel   <= 2'b00;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (i_start) begin
         r_run   <= 1'b1;
         r_cnt   <= '0;
         r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
         r_opd   <= w_is_div ? w_b_mag : w_a_mag;
         r_div   <= w_is_div;
         r_sel   <= i_op[1:0];
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
      end else if (r_run) begin
         r_acc <= w_nx;
         r_cnt <= r_cnt + CW'(1);
         if (o_done) r_run <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// Module : alu_mc
// Brief  : Multi-cycle execute ALU with valid/ready handshake and tag pass-through.
//          Macro ALU_MULDIV_EN builds the iterative RV32M multiply/divide path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_mc
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       func,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  res,
   output logic [TAG_W-1:0] tag_out,
   output logic             err,
   output logic             busy
);

   localparam int SHW = shamt_w(XLEN);

   logic [1:0]       r_state;
   logic [XLEN-1:0]  r_res;
   logic [TAG_W-1:0] r_tag;
   logic             r_err;

   logic             w_accept, w_base_ok, w_acc_err, w_acc_iter, w_md_done;
   logic [XLEN-1:0]  w_base_res, w_acc_res, w_md_res;
   logic [SHW-1:0]   w_shamt;

   assign w_shamt   = b[SHW-1:0];
   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == S_DONE);
   assign res       = r_res;
   assign tag_out   = r_tag;
   assign err       = r_err;

   always_comb begin
      w_base_res = '0;
      w_base_ok  = 1'b1;
      case (func)
         F_ADD:   w_base_res = a + b;
         F_SUB:   w_base_res = a - b;
         F_SLT:   w_base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         F_SLTU:  w_base_res = {{(XLEN-1){1'b0}}, (a < b)};
         F_AND:   w_base_res = a & b;
         F_OR:    w_base_res = a | b;
         F_XOR:   w_base_res = a ^ b;
         F_SLL:   w_base_res = a << w_shamt;
         F_SRL:   w_base_res = a >> w_shamt;
         F_SRA:   w_base_res = $unsigned($signed(a) >>> w_shamt);
         default: w_base_ok  = 1'b0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic            w_is_m, w_md_bypass, w_md_start;
   logic [XLEN-1:0] w_md_byp_res;

   assign w_is_m     = (func[4:3] == 2'b10);
   assign w_md_start = w_accept && w_is_m && !w_md_bypass;
   assign busy       = (r_state == S_BUSY);

   alu_muldiv_iter #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk          (clock),
      .rst          (reset),
      .i_start      (w_md_start),
      .i_op         (func[2:0]),
      .i_a          (a),
      .i_b          (b),
      .o_done       (w_md_done),
      .o_res        (w_md_res),
      .o_bypass     (w_md_bypass),
      .o_bypass_res (w_md_byp_res)
   );

   always_comb begin
      w_acc_res  = w_base_ok ? w_base_res : '0;
      w_acc_err  = !w_base_ok;
      w_acc_iter = 1'b0;
      if (w_is_m) begin
         w_acc_res  = w_md_bypass ? w_md_byp_res : '0;
         w_acc_err  = 1'b0;
         w_acc_iter = !w_md_bypass;
      end
   end
`else
   assign busy      = 1'b0;
   assign w_md_done = 1'b0;
   assign w_md_res  = '0;

   always_comb begin
      w_acc_res  = w_base_ok ? w_base_res : '0;
      w_acc_err  = !w_base_ok;
      w_acc_iter = 1'b0;
   end
`endif

   // An accept in DONE (out_ready high) restarts exactly like an accept in IDLE
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_res   <= '0;
         r_tag   <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_tag <= tag_in;
         if (w_acc_iter) begin
            r_state <= S_BUSY;
         end else begin
            r_state <= S_DONE;
            r_res   <= w_acc_res;
            r_err   <= w_acc_err;
         end
      end else if ((r_state == S_DONE) && out_ready) begin
         r_state <= S_IDLE;
      end else if ((r_state == S_BUSY) && w_md_done) begin
         r_state <= S_DONE;
         r_res   <= w_md_res;
         r_err   <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module : tb_alu_mc
// Brief  : Self-checking bench for alu_mc: directed literals plus random ops
//          against a behavioural model; follows ALU_MULDIV_EN if defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [4:0]       func = '0;
   logic [XLEN-1:0]  a = '0;
   logic [XLEN-1:0]  b = '0;
   logic [TAG_W-1:0] tag_in = '0;
   logic             in_ready, out_valid, err, busy;
   logic [XLEN-1:0]  res;
   logic [TAG_W-1:0] tag_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit rand_ready = 1'b0;

   alu_mc #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .func(func), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid),
      .out_ready(out_ready), .res(res), .tag_out(tag_out), .err(err), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Returns {err, res} computed with wide signed/unsigned arithmetic
   function automatic logic [32:0] model(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, p;
      logic [63:0] ux, uy, up;
      logic [31:0] r;
      logic e;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'd0, x};
      uy = {32'd0, y};
      r = '0;
      e = 1'b0;
      p = '0;
      up = '0;
      case (f)
         5'h00: r = x + y;
         5'h08: r = x - y;
         5'h01: r = (sx < sy) ? 32'd1 : 32'd0;
         5'h02: r = (x < y) ? 32'd1 : 32'd0;
         5'h03: r = x & y;
         5'h04: r = x | y;
         5'h05: r = x ^ y;
         5'h06: r = x << y[4:0];
         5'h07: r = x >> y[4:0];
         5'h09: begin p = sx >>> y[4:0]; r = p[31:0]; end
         default: e = 1'b1;
      endcase
      if (MD && f >= 5'h10 && f <= 5'h17) begin
         e = 1'b0;
         case (f)
            5'h10: begin p = sx * sy; r = p[31:0]; end
            5'h11: begin p = sx * sy; r = p[63:32]; end
            5'h12: begin p = sx * $signed(uy); r = p[63:32]; end
            5'h13: begin up = ux * uy; r = up[63:32]; end
            5'h14: if (y == 0) r = 32'hFFFFFFFF;
                   else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                   else begin p = sx / sy; r = p[31:0]; end
            5'h15: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            5'h16: if (y == 0) r = x;
                   else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
                   else begin p = sx % sy; r = p[31:0]; end
            default: r = (y == 0) ? x : x % y;
         endcase
      end
      if (e) r = '0;
      return {e, r};
   endfunction

   function automatic int latency(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
      bit sdiv_ovf;
      if (!MD || f < 5'h10 || f > 5'h17) return 1;
      sdiv_ovf = (f == 5'h14 || f == 5'h16) && x == 32'h80000000 && y == 32'hFFFFFFFF;
      if (f >= 5'h14 && (y == 0 || sdiv_ovf)) return 1;
      return XLEN + 1;
   endfunction

   typedef struct {
      logic [31:0] r;
      logic        e;
      logic [4:0]  t;
      int          due;
      bit          iter;
   } exp_t;
   exp_t q[$];

   // Cycle-by-cycle compare of every output against the pending-op queue
   always @(negedge clock) begin
      bit ev, eb, er;
      logic [32:0] m;
      exp_t x;
      if (reset) begin
         q.delete();
      end else begin
         ev = (q.size() > 0) && (cyc >= q[0].due);
         eb = (q.size() > 0) && q[0].iter && !ev;
         er = (q.size() == 0) || (ev && out_ready);
         chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
         chk("busy", {31'd0, busy}, {31'd0, eb});
         chk("in_ready", {31'd0, in_ready}, {31'd0, er});
         if (ev && out_valid) begin
            chk("res", res, q[0].r);
            chk("err", {31'd0, err}, {31'd0, q[0].e});
            chk("tag_out", {27'd0, tag_out}, {27'd0, q[0].t});
         end
         if (ev && out_ready) void'(q.pop_front());
         if (in_valid && er) begin
            m = model(func, a, b);
            x.r = m[31:0];
            x.e = m[32];
            x.t = tag_in;
            x.due = cyc + latency(func, a, b);
            x.iter = latency(func, a, b) > 1;
            q.push_back(x);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic issue(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
      int n;
      func = f; a = x; b = y; tag_in = t; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic dir(input string nm, input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic ee, input int lat);
      int n, nb;
      out_ready = 1'b1;
      issue(f, x, y, 5'h15);
      n = 0;
      nb = 0;
      forever begin
         @(negedge clock);
         n++;
         if (busy) nb++;
         if (out_valid || n > 100) break;
      end
      chk({nm, "_lat"}, n, lat);
      chk({nm, "_busycyc"}, nb, lat - 1);
      chk({nm, "_res"}, res, er);
      chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      logic [4:0] f;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_res", res, 32'd0);
      chk("rst_tag", {27'd0, tag_out}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clock);
      #1;

      chk("model_mulh", model(5'h11, 32'h80000000, 32'h80000000) & {MD, 32'hFFFFFFFF},
          MD ? 33'h040000000 : 33'h0);
      chk("model_sra", model(5'h09, 32'h80000000, 32'h21), 32'hC0000000);
      chk("model_rem", model(5'h16, 32'hFFFFFFF9, 32'd2), MD ? 32'hFFFFFFFF : 32'd0);

      dir("add", 5'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1);
      dir("sub", 5'h08, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1);
      dir("slt", 5'h01, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
      dir("sltu", 5'h02, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
      dir("sra", 5'h09, 32'h80000000, 32'h21, 32'hC0000000, 1'b0, 1);
      dir("sll", 5'h06, 32'd1, 32'h1F, 32'h80000000, 1'b0, 1);
      dir("illegal", 5'h0A, 32'h1234, 32'h5678, 32'd0, 1'b1, 1);
      if (MD) begin
         dir("divu", 5'h15, 32'd100, 32'd7, 32'd14, 1'b0, 33);
         dir("rem", 5'h16, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
         dir("div0", 5'h14, 32'd55, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
         dir("divovf", 5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
         dir("mulh", 5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
         dir("mulhu", 5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
         dir("mul", 5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33);
      end else begin
         dir("mul_off", 5'h10, 32'd3, 32'd4, 32'd0, 1'b1, 1);
      end

      // Back-pressure: hold result for 3 cycles, then back-to-back accept
      out_ready = 1'b0;
      issue(5'h00, 32'd5, 32'd6, 5'd9);
      repeat (3) begin
         @(negedge clock);
         chk("bp_res", res, 32'd11);
         chk("bp_tag", {27'd0, tag_out}, 32'd9);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      func = 5'h05; a = 32'hF0; b = 32'hFF; tag_in = 5'd10; in_valid = 1'b1;
      @(negedge clock);
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      @(negedge clock);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_res", res, 32'h0F);
      chk("b2b_tag", {27'd0, tag_out}, 32'd10);
      @(posedge clock);
      #1;

      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         n = $urandom_range(0, 9);
         if (n < 6) f = 5'($urandom_range(0, 9));
         else if (n < 9) f = 5'(5'h10 + $urandom_range(0, 7));
         else f = 5'($urandom_range(0, 31));
         issue(f, pick(), pick(), 5'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(posedge clock);
      #1;

      // Reset aborts an op in flight; nothing may emerge afterwards
      if (MD) begin
         issue(5'h15, 32'd1000, 32'd3, 5'd7);
         repeat (9) @(posedge clock);
      end else begin
         out_ready = 1'b0;
         issue(5'h00, 32'd1, 32'd2, 5'd7);
      end
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      n = 0;
      repeat (40) begin
         @(negedge clock);
         if (out_valid) n++;
      end
      chk("abort_no_result", n, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
